// File: rtl/loader_pkg.sv
// Shared types and frame-field widths for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {HDR, DATA, CHK, DONE, ERR} state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
interface program_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/byte_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; pulses word_valid on the last byte.
module byte_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic              partial
);

  logic [LANE_W-1:0]        lane;
  logic [WORD_W-BYTE_W-1:0] low_bytes;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane      <= '0;
      low_bytes <= '0;
    end else if (clear) begin
      lane      <= '0;
      low_bytes <= '0;
    end else if (byte_valid) begin
      lane      <= lane + 1'b1;
      low_bytes <= {byte_data, low_bytes[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end

  // word_valid must not depend on clear: clear is derived from the FSM's next state.
  assign word_valid = byte_valid && (lane == LANE_W'(BYTES_PER_WORD - 1));
  assign word       = {byte_data, low_bytes};
  assign partial    = (lane != '0);

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives header/words/checksum, writes instruction memory, releases the CPU.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  program_loader_if.slave       in_if,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_run,
  output logic                  busy,
  output logic                  err,
  output logic [CNT_W-1:0]      words_loaded
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, state_next;
  logic              accept, word_valid, partial, clear, timer_run, timed_out;
  logic [WORD_W-1:0] word, n_words, csum;
  logic [TO_W-1:0]   idle_cnt;

  assign in_if.in_ready = (state == HDR) || (state == DATA) || (state == CHK);
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign busy           = in_if.in_ready;
  assign cpu_run        = (state == DONE);
  assign err            = (state == ERR);

  assign timer_run = (state == DATA) || (state == CHK) || ((state == HDR) && partial);
  assign timed_out = timer_run && !accept && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign clear     = (state_next != state);

  byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst),
    .clear      (clear),
    .byte_valid (accept),
    .byte_data  (in_if.in_data),
    .word_valid (word_valid),
    .word       (word),
    .partial    (partial)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HDR;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (timed_out)       state_next = ERR;
        else if (word_valid) state_next = ((word == '0) || (word > WORD_W'(MEM_WORDS))) ? ERR : DATA;
      end
      DATA: begin
        if (timed_out) state_next = ERR;
        else if (word_valid && (WORD_W'(words_loaded) == n_words - 1)) state_next = CHK;
      end
      CHK: begin
        if (timed_out)       state_next = ERR;
        else if (word_valid) state_next = (word == csum) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (reload) state_next = HDR;
      end
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt <= '0;
    else if (!timer_run || accept) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + 1'b1;
  end

  // words_loaded doubles as the write index; it holds its value in DONE/ERR until reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_words      <= '0;
      csum         <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      if ((state == HDR) && (state_next == DATA)) begin
        n_words      <= word;
        csum         <= '0;
        words_loaded <= '0;
      end
      if (((state == DONE) || (state == ERR)) && (state_next == HDR)) begin
        csum         <= '0;
        words_loaded <= '0;
      end
      if ((state == DATA) && word_valid) begin
        imem_we      <= 1'b1;
        imem_addr    <= 32'(words_loaded) << 2;
        imem_wdata   <= word;
        csum         <= csum ^ word;
        words_loaded <= words_loaded + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized framed streams against a frame-level model.
module tb_program_loader;

  localparam int unsigned MEM_WORDS = 256;
  localparam int unsigned TIMEOUT   = 64;
  localparam int unsigned CNT_W     = 16;

  typedef logic [7:0] byte_q_t[$];

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             reload = 1'b0;
  logic             imem_we, cpu_run, busy, err;
  logic [31:0]      imem_addr, imem_wdata;
  logic [CNT_W-1:0] words_loaded;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned edge_no = 0;

  int unsigned acc_edge[$];
  logic [31:0] wr_addr[$], wr_data[$];
  int unsigned wr_edge[$];

  logic [31:0] exp_addr[$], exp_data[$];
  bit          exp_done;
  int unsigned exp_words;

  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader #(
    .MEM_WORDS      (MEM_WORDS),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (bus),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always @(posedge clk) edge_no <= edge_no + 1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_edge.push_back(edge_no);
    end
  end

  function automatic byte_q_t build_frame(input logic [31:0] n, input logic [31:0] words[$],
                                          input logic [31:0] cs);
    byte_q_t     f;
    logic [31:0] t;
    for (int k = 0; k < 4; k++) f.push_back(n[8*k +: 8]);
    foreach (words[i]) begin
      t = words[i];
      for (int k = 0; k < 4; k++) f.push_back(t[8*k +: 8]);
    end
    for (int k = 0; k < 4; k++) f.push_back(cs[8*k +: 8]);
    return f;
  endfunction

  function automatic logic [31:0] xor_all(input logic [31:0] words[$]);
    logic [31:0] x = '0;
    foreach (words[i]) x ^= words[i];
    return x;
  endfunction

  // Frame-level reference: expected writes, final outcome and word count.
  function automatic void model(input byte_q_t f);
    logic [31:0] n, w, x, cs;
    exp_addr.delete();
    exp_data.delete();
    x = '0;
    n = {f[3], f[2], f[1], f[0]};
    if (n == 0 || n > MEM_WORDS) begin
      exp_done  = 1'b0;
      exp_words = 0;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w = {f[4+4*i+3], f[4+4*i+2], f[4+4*i+1], f[4+4*i]};
      exp_addr.push_back(32'(4 * i));
      exp_data.push_back(w);
      x ^= w;
    end
    cs = {f[4+4*n+3], f[4+4*n+2], f[4+4*n+1], f[4+4*n]};
    exp_words = n;
    exp_done  = (cs == x);
  endfunction

  task automatic start_frame();
    acc_edge.delete();
    wr_addr.delete();
    wr_data.delete();
    wr_edge.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int w = 0; w < 20 && !ok; w++) begin
      if (bus.in_ready === 1'b1) begin
        acc_edge.push_back(edge_no + 1);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL byte_accept: in_ready=%b after 20 cycles, required 1", bus.in_ready);
    end
  endtask

  task automatic send_frame(input byte_q_t f, input int unsigned gap_max);
    int unsigned gap;
    foreach (f[i]) begin
      gap = (gap_max != 0) ? $urandom_range(gap_max, 0) : 0;
      repeat (gap) begin
        bus.in_data = 8'($urandom);
        reload = ($urandom_range(3, 0) == 0);
        @(negedge clk);
        reload = 1'b0;
      end
      send_byte(f[i]);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.in_ready, busy, cpu_run, err, imem_we} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_flags: got ready,busy,run,err,we=%b, required 11000",
               {bus.in_ready, busy, cpu_run, err, imem_we});
    end
    checks++;
    if ({words_loaded, imem_addr, imem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_values: got words=%0d addr=%h data=%h, required all 0",
               words_loaded, imem_addr, imem_wdata);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    logic [31:0] w[$];
    byte_q_t f;
    w = {32'h00500093, 32'h00A00113};
    f = build_frame(32'd2, w, 32'h00F00180);
    start_frame();
    model(f);
    send_frame(f, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr.size() != exp_addr.size()) begin
      failures++;
      $display("FAIL basic write_count: got %0d, required %0d", wr_addr.size(), exp_addr.size());
    end else foreach (exp_addr[i]) begin
      checks++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i] || wr_edge[i] !== acc_edge[4+4*i+3]) begin
        failures++;
        $display("FAIL basic write[%0d]: got addr=%h data=%h edge=%0d, required addr=%h data=%h edge=%0d",
                 i, wr_addr[i], wr_data[i], wr_edge[i], exp_addr[i], exp_data[i], acc_edge[4+4*i+3]);
      end
    end
    checks++;
    if ({cpu_run, err, words_loaded} !== {exp_done, !exp_done, CNT_W'(exp_words)}) begin
      failures++;
      $display("FAIL basic status: got run=%b err=%b words=%0d, required run=%b err=%b words=%0d",
               cpu_run, err, words_loaded, exp_done, !exp_done, exp_words);
    end
    checks++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_ready: got in_ready=%b busy=%b, required 0 0", bus.in_ready, busy);
    end
  endtask

  task automatic test_bad_checksum();
    logic [31:0] w[$];
    byte_q_t f;
    w = {32'h00500093, 32'h00A00113};
    f = build_frame(32'd2, w, 32'h00000000);
    pulse_reload();
    checks++;
    if ({cpu_run, busy, words_loaded} !== {1'b0, 1'b1, CNT_W'(0)}) begin
      failures++;
      $display("FAIL reload_from_done: got run=%b busy=%b words=%0d, required 0 1 0",
               cpu_run, busy, words_loaded);
    end
    start_frame();
    model(f);
    send_frame(f, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr.size() != exp_addr.size()) begin
      failures++;
      $display("FAIL badcs write_count: got %0d, required %0d", wr_addr.size(), exp_addr.size());
    end else foreach (exp_addr[i]) begin
      checks++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL badcs write[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                 i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if ({cpu_run, err} !== {exp_done, !exp_done}) begin
      failures++;
      $display("FAIL badcs status: got run=%b err=%b, required run=%b err=%b",
               cpu_run, err, exp_done, !exp_done);
    end
  endtask

  task automatic test_illegal_count();
    logic [31:0] counts[3];
    logic [31:0] none[$];
    byte_q_t f, hdr;
    counts = '{32'd0, 32'd257, 32'hFFFFFFFF};
    foreach (counts[c]) begin
      pulse_reload();
      f = build_frame(counts[c], none, 32'h0);
      hdr = f[0:3];
      start_frame();
      send_frame(hdr, 2);
      repeat (3) @(negedge clk);
      checks++;
      if ({err, cpu_run, busy} !== 3'b100 || wr_addr.size() != 0) begin
        failures++;
        $display("FAIL illegal_count N=%h: got err=%b run=%b busy=%b writes=%0d, required 1 0 0 writes=0",
                 counts[c], err, cpu_run, busy, wr_addr.size());
      end
    end
  endtask

  task automatic test_random_backpressure();
    logic [31:0] w[$], cs;
    byte_q_t f;
    int unsigned n, gap_max;
    for (int t = 0; t < 8; t++) begin
      w.delete();
      n = (t == 7) ? MEM_WORDS : $urandom_range(8, 1);
      for (int i = 0; i < int'(n); i++) w.push_back($urandom);
      cs = xor_all(w);
      if (t != 7 && $urandom_range(2, 0) == 0) cs ^= 32'(1) << $urandom_range(31, 0);
      gap_max = (t == 7) ? 0 : 5;
      f = build_frame(32'(n), w, cs);
      pulse_reload();
      start_frame();
      model(f);
      send_frame(f, gap_max);
      repeat (3) @(negedge clk);
      checks++;
      if (wr_addr.size() != exp_addr.size()) begin
        failures++;
        $display("FAIL rand%0d write_count: got %0d, required %0d", t, wr_addr.size(), exp_addr.size());
      end else foreach (exp_addr[i]) begin
        checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i] || wr_edge[i] !== acc_edge[4+4*i+3]) begin
          failures++;
          $display("FAIL rand%0d write[%0d]: got addr=%h data=%h edge=%0d, required addr=%h data=%h edge=%0d",
                   t, i, wr_addr[i], wr_data[i], wr_edge[i], exp_addr[i], exp_data[i], acc_edge[4+4*i+3]);
        end
      end
      checks++;
      if ({cpu_run, err, words_loaded} !== {exp_done, !exp_done, CNT_W'(exp_words)}) begin
        failures++;
        $display("FAIL rand%0d status: got run=%b err=%b words=%0d, required run=%b err=%b words=%0d",
                 t, cpu_run, err, words_loaded, exp_done, !exp_done, exp_words);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] w[$];
    byte_q_t f;
    w = {32'h12345678};
    f = build_frame(32'd1, w, 32'h12345678);
    pulse_reload();
    repeat (2 * TIMEOUT) @(negedge clk);
    checks++;
    if ({busy, err} !== 2'b10) begin
      failures++;
      $display("FAIL idle_hdr_no_timeout: got busy=%b err=%b, required 1 0", busy, err);
    end
    start_frame();
    for (int i = 0; i < 6; i++) send_byte(f[i]);
    repeat (TIMEOUT - 2) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: got err=%b before limit, required 0", err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({err, cpu_run, busy} !== 3'b100) begin
      failures++;
      $display("FAIL timeout_err: got err=%b run=%b busy=%b, required 1 0 0", err, cpu_run, busy);
    end
    pulse_reload();
    start_frame();
    send_frame(f, 3);
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_run, err, words_loaded} !== {2'b10, CNT_W'(1)} || wr_data.size() != 1) begin
      failures++;
      $display("FAIL timeout_recover: got run=%b err=%b words=%0d writes=%0d, required 1 0 1 writes=1",
               cpu_run, err, words_loaded, wr_data.size());
    end
  endtask

  task automatic test_midframe_reset_reload();
    logic [31:0] w[$];
    byte_q_t f;
    w = {32'h00500093, 32'h00A00113};
    f = build_frame(32'd2, w, 32'h00F00180);
    pulse_reload();
    start_frame();
    for (int i = 0; i < 8; i++) send_byte(f[i]);
    repeat (2) @(negedge clk);
    checks++;
    if (wr_data.size() != 1 || words_loaded !== CNT_W'(1)) begin
      failures++;
      $display("FAIL midframe_pre: got writes=%0d words=%0d, required 1 1", wr_data.size(), words_loaded);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, busy, cpu_run, err, imem_we, words_loaded} !== {5'b11000, CNT_W'(0)}) begin
      failures++;
      $display("FAIL midframe_reset: got ready,busy,run,err,we=%b words=%0d, required 11000 words=0",
               {bus.in_ready, busy, cpu_run, err, imem_we}, words_loaded);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_frame();
    send_frame(f, 2);
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_run, err} !== 2'b10) begin
      failures++;
      $display("FAIL reload_setup: got run=%b err=%b, required 1 0", cpu_run, err);
    end
    reload = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    #1;
    checks++;
    if ({bus.in_ready, cpu_run} !== 2'b01) begin
      failures++;
      $display("FAIL reload_with_valid: got in_ready=%b run=%b, required 0 1", bus.in_ready, cpu_run);
    end
    @(negedge clk);
    reload = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if ({cpu_run, err, busy, words_loaded} !== {3'b001, CNT_W'(0)}) begin
      failures++;
      $display("FAIL reload_drop: got run=%b err=%b busy=%b words=%0d, required 0 0 1 0",
               cpu_run, err, busy, words_loaded);
    end
    // A byte wrongly taken alongside the reload would start the header timer.
    repeat (2 * TIMEOUT) @(negedge clk);
    checks++;
    if ({err, busy} !== 2'b01) begin
      failures++;
      $display("FAIL reload_byte_ignored: got err=%b busy=%b, required 0 1", err, busy);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_basic_load();
    test_bad_checksum();
    test_illegal_count();
    test_random_backpressure();
    test_timeout();
    test_midframe_reset_reload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
